stack_sequencer: RTL and testbench

- Multi-cycle controller that sequences stack-pointer updates and data-memory accesses for CALL, RET, INT and RTI.
- Owns the stack pointer (SP). Stalls the pipeline via busy while it issues one or two push/pop accesses on the data-memory port.
- Returns popped PC/flags to fetch and the flag register with a one-cycle valid pulse.
- Stack grows downward: push writes mem[SP] then decrements SP; pop increments SP then reads mem[SP].

---
 rtl/stack_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_stack_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// Stack sequencer: owns SP and sequences push/pop accesses for CALL, RET, INT and RTI.
// Optional bounds checking is enabled with `define STACK_BOUNDS_CHECK_EN.
module stack_sequencer #(
    parameter int                 ADDR_W   = 32,
    parameter int                 FLAG_W   = 4,
    parameter logic [ADDR_W-1:0]  SP_INIT  = 32'h000F_FFFF,
    parameter logic [ADDR_W-1:0]  SP_LIMIT = 32'h000F_F000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cmd,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] sp_out,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic [FLAG_W-1:0] flags_out,
    output logic              flags_valid,
    output logic              stack_err
);

    localparam logic [1:0] CMD_CALL = 2'b00;
    localparam logic [1:0] CMD_RET  = 2'b01;
    localparam logic [1:0] CMD_INT  = 2'b10;
    localparam logic [1:0] CMD_RTI  = 2'b11;

    localparam logic [ADDR_W-1:0] SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH1 = 3'd1,
        S_PUSH2 = 3'd2,
        S_POP1  = 3'd3,
        S_CAP1  = 3'd4,
        S_CAP2  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [ADDR_W-1:0]  sp_r;
    logic [ADDR_W-1:0]  sp_s;
    logic [1:0]         cmd_r;
    logic [FLAG_W-1:0]  flags_r;
    logic               err_s;
    logic               we_s;
    logic               re_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [ADDR_W-1:0]  wdata_s;
    logic               pc_valid_s;
    logic               flags_valid_s;

`ifdef STACK_BOUNDS_CHECK_EN
    // One extra bit so that SP+1/SP+2 and SP_LIMIT+1 cannot wrap during the compare.
    logic [ADDR_W:0] sp_x_s;
    assign sp_x_s = {1'b0, sp_r};
    localparam logic [ADDR_W:0] ONE_X  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] TWO_X  = {{(ADDR_W-1){1'b0}}, 2'b10};
    localparam logic [ADDR_W:0] INIT_X = {1'b0, SP_INIT};
    localparam logic [ADDR_W:0] LIM_X  = {1'b0, SP_LIMIT};
`endif

    assign sp_out = sp_r;

    // Next-state, next-SP and next-cycle output decode; outputs are registered from these.
    always_comb begin
        state_s       = state_r;
        sp_s          = sp_r;
        err_s         = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
`ifdef STACK_BOUNDS_CHECK_EN
                    case (cmd)
                        CMD_CALL: err_s = (sp_x_s < LIM_X);
                        CMD_INT:  err_s = (sp_x_s < (LIM_X + ONE_X));
                        CMD_RET:  err_s = ((sp_x_s + ONE_X) > INIT_X);
                        CMD_RTI:  err_s = ((sp_x_s + TWO_X) > INIT_X);
                        default:  err_s = 1'b0;
                    endcase
`endif
                    if (err_s) begin
                        state_s = S_DONE;
                    end else if (cmd[0]) begin
                        state_s = S_POP1;
                    end else begin
                        state_s = S_PUSH1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PUSH1: begin
                sp_s    = sp_r - SP_ONE;
                state_s = (cmd_r == CMD_INT) ? S_PUSH2 : S_DONE;
            end
            S_PUSH2: begin
                sp_s    = sp_r - SP_ONE;
                state_s = S_DONE;
            end
            S_POP1: begin
                sp_s    = sp_r + SP_ONE;
                state_s = S_CAP1;
            end
            S_CAP1: begin
                if (cmd_r == CMD_RTI) begin
                    sp_s    = sp_r + SP_ONE;
                    state_s = S_CAP2;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_CAP2:  state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase

        // A push addresses the SP it starts with; a pop addresses the SP after its increment.
        we_s    = (state_s == S_PUSH1) || (state_s == S_PUSH2);
        re_s    = (state_s == S_POP1) || ((state_s == S_CAP1) && (cmd_r == CMD_RTI));
        if (we_s) begin
            addr_s = sp_s;
        end else if (re_s) begin
            addr_s = sp_s + SP_ONE;
        end else begin
            addr_s = {ADDR_W{1'b0}};
        end
        if (state_s == S_PUSH1) begin
            wdata_s = pc_in;
        end else if (state_s == S_PUSH2) begin
            wdata_s = {{(ADDR_W-FLAG_W){1'b0}}, flags_r};
        end else begin
            wdata_s = {ADDR_W{1'b0}};
        end
        pc_valid_s    = (state_s == S_DONE) && (state_r != S_IDLE) && cmd_r[0];
        flags_valid_s = (state_s == S_DONE) && (state_r != S_IDLE) && (cmd_r == CMD_RTI);
    end

    // State, SP, latched request, captured pop data and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            sp_r        <= SP_INIT;
            cmd_r       <= 2'b00;
            flags_r     <= {FLAG_W{1'b0}};
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_wdata   <= {ADDR_W{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            pc_out      <= {ADDR_W{1'b0}};
            pc_valid    <= 1'b0;
            flags_out   <= {FLAG_W{1'b0}};
            flags_valid <= 1'b0;
            stack_err   <= 1'b0;
        end else begin
            state_r     <= state_s;
            sp_r        <= sp_s;
            if ((state_r == S_IDLE) && start) begin
                cmd_r   <= cmd;
                flags_r <= flags_in;
            end
            mem_we      <= we_s;
            mem_re      <= re_s;
            mem_addr    <= addr_s;
            mem_wdata   <= wdata_s;
            busy        <= (state_s != S_IDLE);
            done        <= (state_s == S_DONE);
            pc_valid    <= pc_valid_s;
            flags_valid <= flags_valid_s;
            stack_err   <= err_s;
            if (state_r == S_CAP1) begin
                if (cmd_r == CMD_RTI) begin
                    flags_out <= mem_rdata[FLAG_W-1:0];
                end else begin
                    pc_out    <= mem_rdata;
                end
            end else if (state_r == S_CAP2) begin
                pc_out <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed self-checking bench for stack_sequencer with a 1-cycle-latency memory model.
module tb_stack_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  cmd;
    logic [31:0] pc_in;
    logic [3:0]  flags_in;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] sp_out;
    logic        busy;
    logic        done;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic [3:0]  flags_out;
    logic        flags_valid;
    logic        stack_err;

    int passed;
    int total;

    logic [31:0] mem [0:255];

    stack_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .pc_in(pc_in),
        .flags_in(flags_in), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .sp_out(sp_out), .busy(busy), .done(done), .pc_out(pc_out),
        .pc_valid(pc_valid), .flags_out(flags_out), .flags_valid(flags_valid),
        .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: write on we, registered read data one cycle after re.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [1:0] c, input logic [31:0] pc, input logic [3:0] fl);
        start = 1'b1; cmd = c; pc_in = pc; flags_in = fl;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        total++; if (sp_out !== 32'h000F_FFFF) $display("FAIL reset_sp: got %h want %h", sp_out, 32'h000F_FFFF); else passed++;
        total++; if ({busy, done, mem_we, mem_re, pc_valid, flags_valid, stack_err} !== 7'b0000000)
            $display("FAIL reset_strobes: got %b want %b", {busy, done, mem_we, mem_re, pc_valid, flags_valid, stack_err}, 7'b0000000); else passed++;
        total++; if ({pc_out, flags_out} !== 36'h0) $display("FAIL reset_pops: got %h want %h", {pc_out, flags_out}, 36'h0); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_call();
        issue(2'b00, 32'h0000_0100, 4'h0);
        total++; if ({busy, done, mem_we, mem_re} !== 4'b1010) $display("FAIL call_c1_ctl: got %b want %b", {busy, done, mem_we, mem_re}, 4'b1010); else passed++;
        total++; if ({mem_addr, mem_wdata} !== {32'h000F_FFFF, 32'h0000_0100})
            $display("FAIL call_c1_bus: got %h want %h", {mem_addr, mem_wdata}, {32'h000F_FFFF, 32'h0000_0100}); else passed++;
        step();
        total++; if ({busy, done, mem_we, mem_re, pc_valid, flags_valid, stack_err} !== 7'b1100000)
            $display("FAIL call_c2_ctl: got %b want %b", {busy, done, mem_we, mem_re, pc_valid, flags_valid, stack_err}, 7'b1100000); else passed++;
        total++; if (sp_out !== 32'h000F_FFFE) $display("FAIL call_sp: got %h want %h", sp_out, 32'h000F_FFFE); else passed++;
        step();
        total++; if ({busy, done} !== 2'b00) $display("FAIL call_idle: got %b want %b", {busy, done}, 2'b00); else passed++;
        total++; if (mem[8'hFF] !== 32'h0000_0100) $display("FAIL call_mem: got %h want %h", mem[8'hFF], 32'h0000_0100); else passed++;
    endtask

    task automatic test_ret();
        issue(2'b01, 32'h0, 4'h0);
        total++; if ({busy, done, mem_we, mem_re, mem_addr} !== {4'b1001, 32'h000F_FFFF})
            $display("FAIL ret_c1: got %h want %h", {busy, done, mem_we, mem_re, mem_addr}, {4'b1001, 32'h000F_FFFF}); else passed++;
        step();
        total++; if ({busy, done, mem_re, sp_out} !== {3'b100, 32'h000F_FFFF})
            $display("FAIL ret_c2: got %h want %h", {busy, done, mem_re, sp_out}, {3'b100, 32'h000F_FFFF}); else passed++;
        step();
        total++; if ({busy, done, pc_valid, flags_valid} !== 4'b1110)
            $display("FAIL ret_done: got %b want %b", {busy, done, pc_valid, flags_valid}, 4'b1110); else passed++;
        total++; if (pc_out !== 32'h0000_0100) $display("FAIL ret_pc: got %h want %h", pc_out, 32'h0000_0100); else passed++;
        step();
        total++; if ({busy, pc_valid, pc_out} !== {2'b00, 32'h0000_0100})
            $display("FAIL ret_hold: got %h want %h", {busy, pc_valid, pc_out}, {2'b00, 32'h0000_0100}); else passed++;
    endtask

    task automatic test_int();
        do_reset();
        issue(2'b10, 32'h0000_0200, 4'b1010);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h000F_FFFF, 32'h0000_0200})
            $display("FAIL int_c1: got %h want %h", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h000F_FFFF, 32'h0000_0200}); else passed++;
        step();
        total++; if ({busy, done, mem_we, mem_addr, mem_wdata} !== {3'b101, 32'h000F_FFFE, 32'h0000_000A})
            $display("FAIL int_c2: got %h want %h", {busy, done, mem_we, mem_addr, mem_wdata}, {3'b101, 32'h000F_FFFE, 32'h0000_000A}); else passed++;
        step();
        total++; if ({busy, done, mem_we, pc_valid, sp_out} !== {4'b1100, 32'h000F_FFFD})
            $display("FAIL int_c3: got %h want %h", {busy, done, mem_we, pc_valid, sp_out}, {4'b1100, 32'h000F_FFFD}); else passed++;
        step();
        total++; if (busy !== 1'b0) $display("FAIL int_idle: got %b want %b", busy, 1'b0); else passed++;
    endtask

    task automatic test_rti();
        issue(2'b11, 32'h0, 4'h0);
        total++; if ({mem_re, mem_we, mem_addr} !== {2'b10, 32'h000F_FFFE})
            $display("FAIL rti_c1: got %h want %h", {mem_re, mem_we, mem_addr}, {2'b10, 32'h000F_FFFE}); else passed++;
        step();
        total++; if ({mem_re, mem_addr, sp_out} !== {1'b1, 32'h000F_FFFF, 32'h000F_FFFE})
            $display("FAIL rti_c2: got %h want %h", {mem_re, mem_addr, sp_out}, {1'b1, 32'h000F_FFFF, 32'h000F_FFFE}); else passed++;
        step();
        total++; if ({busy, done, mem_re, flags_out} !== {3'b100, 4'b1010})
            $display("FAIL rti_c3: got %h want %h", {busy, done, mem_re, flags_out}, {3'b100, 4'b1010}); else passed++;
        step();
        total++; if ({busy, done, pc_valid, flags_valid, stack_err} !== 5'b11110)
            $display("FAIL rti_done: got %b want %b", {busy, done, pc_valid, flags_valid, stack_err}, 5'b11110); else passed++;
        total++; if ({pc_out, flags_out, sp_out} !== {32'h0000_0200, 4'b1010, 32'h000F_FFFF})
            $display("FAIL rti_vals: got %h want %h", {pc_out, flags_out, sp_out}, {32'h0000_0200, 4'b1010, 32'h000F_FFFF}); else passed++;
        step();
        total++; if ({busy, done} !== 2'b00) $display("FAIL rti_idle: got %b want %b", {busy, done}, 2'b00); else passed++;
    endtask

    task automatic test_back_to_back();
        int writes;
        int dones;
        int first_we;
        int last_we;
        writes = 0; dones = 0; first_we = -1; last_we = -1;
        do_reset();
        start = 1'b1; cmd = 2'b00; pc_in = 32'h0000_0300; flags_in = 4'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 5) start = 1'b0;
            if (mem_we) begin
                writes++;
                if (first_we < 0) first_we = i;
                last_we = i;
            end
            if (done) dones++;
        end
        total++; if (writes !== 2) $display("FAIL b2b_writes: got %0d want %0d", writes, 2); else passed++;
        total++; if (dones !== 2) $display("FAIL b2b_dones: got %0d want %0d", dones, 2); else passed++;
        total++; if (last_we - first_we !== 3) $display("FAIL b2b_spacing: got %0d want %0d", last_we - first_we, 3); else passed++;
        total++; if (sp_out !== 32'h000F_FFFD) $display("FAIL b2b_sp: got %h want %h", sp_out, 32'h000F_FFFD); else passed++;
    endtask

    task automatic test_reset_midop();
        int dones;
        dones = 0;
        do_reset();
        issue(2'b10, 32'h0000_0200, 4'b1010);
        step();
        total++; if ({mem_we, mem_addr} !== {1'b1, 32'h000F_FFFE})
            $display("FAIL midrst_push2: got %h want %h", {mem_we, mem_addr}, {1'b1, 32'h000F_FFFE}); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if ({busy, done, mem_we, sp_out} !== {3'b000, 32'h000F_FFFF})
            $display("FAIL midrst_async: got %h want %h", {busy, done, mem_we, sp_out}, {3'b000, 32'h000F_FFFF}); else passed++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done || busy) dones++;
        end
        total++; if (dones !== 0) $display("FAIL midrst_quiet: got %0d want %0d", dones, 0); else passed++;
        test_call();
    endtask

    task automatic test_bounds();
        do_reset();
        issue(2'b01, 32'h0, 4'h0);
`ifdef STACK_BOUNDS_CHECK_EN
        total++; if ({busy, done, stack_err, mem_re, mem_we, pc_valid, flags_valid} !== 7'b1110000)
            $display("FAIL under_done: got %b want %b", {busy, done, stack_err, mem_re, mem_we, pc_valid, flags_valid}, 7'b1110000); else passed++;
        total++; if (sp_out !== 32'h000F_FFFF) $display("FAIL under_sp: got %h want %h", sp_out, 32'h000F_FFFF); else passed++;
        step();
        total++; if ({busy, done, stack_err, mem_re, sp_out} !== {4'b0000, 32'h000F_FFFF})
            $display("FAIL under_idle: got %h want %h", {busy, done, stack_err, mem_re, sp_out}, {4'b0000, 32'h000F_FFFF}); else passed++;
`else
        total++; if ({mem_re, mem_addr} !== {1'b1, 32'h0010_0000})
            $display("FAIL wrap_read: got %h want %h", {mem_re, mem_addr}, {1'b1, 32'h0010_0000}); else passed++;
        step();
        step();
        total++; if ({done, stack_err, sp_out} !== {2'b10, 32'h0010_0000})
            $display("FAIL wrap_done: got %h want %h", {done, stack_err, sp_out}, {2'b10, 32'h0010_0000}); else passed++;
        step();
        total++; if (busy !== 1'b0) $display("FAIL wrap_idle: got %b want %b", busy, 1'b0); else passed++;
`endif
    endtask

    initial begin
        passed = 0; total = 0;
        rst = 1'b1; start = 1'b0; cmd = 2'b00; pc_in = 32'h0; flags_in = 4'h0;
        test_reset();
        test_call();
        test_ret();
        test_int();
        test_rti();
        test_back_to_back();
        test_reset_midop();
        test_bounds();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
